// File: rtl/ppu_pkg.sv
// Shared types, address map and CPU blocking rules for the PPU memory responder.
package ppu_pkg;

  typedef enum logic [1:0] {
    PPU_IDLE = 2'd0,
    PPU_WAIT = 2'd1,
    PPU_HOLD = 2'd2
  } PPUState;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFEFF;

  localparam logic [1:0] MODE_OAMSCAN = 2'd2;
  localparam logic [1:0] MODE_DRAW    = 2'd3;

  function automatic logic vram_hit(input logic [15:0] a);
    return (a >= VRAM_BASE) && (a <= VRAM_END);
  endfunction

  // VRAM is locked to the CPU only while the PPU is drawing.
  function automatic logic vram_blocked(input logic lcd_en, input logic [1:0] mode);
    return lcd_en && (mode == MODE_DRAW);
  endfunction

  // OAM is locked during both OAM scan and draw.
  function automatic logic oam_blocked(input logic lcd_en, input logic [1:0] mode);
    return lcd_en && ((mode == MODE_OAMSCAN) || (mode == MODE_DRAW));
  endfunction

endpackage

// File: rtl/video_bram.sv
// Single-port read-first synchronous RAM. The addressed byte is read every
// clock and delayed so that it appears READ_LATENCY clocks after the access.
module video_bram #(
  parameter int DEPTH        = 8192,
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem  [DEPTH];
  logic [7:0] r_pipe [READ_LATENCY];

  // Read-first port plus output delay line; a write returns the old byte.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_pipe[0] <= r_mem[i_addr];
    for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign o_rdata = r_pipe[READ_LATENCY-1];

endmodule

// File: rtl/video_mem_responder.sv
// VRAM/OAM responder: serves PPU fetches on two ports and arbitrates CPU
// accesses against them with DMG mode-based blocking. Index 0 = VRAM, 1 = OAM.
module video_mem_responder
  import ppu_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int VRAM_DEPTH   = 8192,
  parameter int OAM_DEPTH    = 160
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [1:0]  mode_in,
  input  logic        lcd_en_in,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_addr_valid_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  input  logic [15:0] oam_addr_in,
  input  logic        oam_addr_valid_in,
  output logic [7:0]  oam_data_out,
  output logic        oam_data_valid_out,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_rd_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_rdata_valid_out
);

  localparam int         VA_W     = $clog2(VRAM_DEPTH);
  localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [8:0] OAM_LIM  = 9'(OAM_DEPTH);

  // $FEA0-$FEFF decodes to the OAM page but holds no RAM.
  function automatic logic oam_hit(input logic [15:0] a);
    return (a >= OAM_BASE) && (a <= OAM_END) && ({1'b0, a[7:0]} < OAM_LIM);
  endfunction

  PPUState          r_state [2];
  PPUState          w_next  [2];
  logic [1:0]       r_cnt   [2];
  logic [7:0]       r_data  [2];
  logic [7:0]       w_ram_q [2];
  logic [1:0]       r_oor;
  logic [1:0]       w_ppu_hit, w_ppu_req, w_acc, w_ppu_ram;

  logic             w_cpu_vram, w_cpu_oam, w_cpu_stb, w_cpu_tgt, w_cpu_blk, w_cpu_conf;
  logic             w_new_go, w_new_pend, w_blk_rd;
  logic             r_pend_vld, r_pend_we, r_pend_tgt;
  logic [VA_W-1:0]  r_pend_addr;
  logic [7:0]       r_pend_wdata;
  logic             w_go, w_go_we, w_go_tgt;
  logic [VA_W-1:0]  w_go_addr;
  logic [7:0]       w_go_wdata;
  logic [READ_LATENCY-1:0] r_rd_sr, r_tgt_sr;

  logic [VA_W-1:0]  w_vram_addr;
  logic [7:0]       w_oam_addr;
  logic             w_vram_we, w_oam_we;

  assign w_ppu_hit = {oam_hit(oam_addr_in), vram_hit(ppu_addr_in)};
  assign w_ppu_req = {oam_addr_valid_in, ppu_addr_valid_in};

  // PPU acceptance: only on a T-cycle strobe, from IDLE or from HOLD.
  always_comb begin
    w_acc = '0;
    for (int p = 0; p < 2; p++)
      w_acc[p] = tclk_in && w_ppu_req[p] &&
                 ((r_state[p] == PPU_IDLE) || (r_state[p] == PPU_HOLD));
  end

  // Out-of-range fetches never touch the RAM, so they cannot stall the CPU.
  assign w_ppu_ram = w_acc & w_ppu_hit;

  // CPU decode; write wins over a simultaneous read.
  assign w_cpu_vram = vram_hit(cpu_addr_in);
  assign w_cpu_oam  = oam_hit(cpu_addr_in);
  assign w_cpu_stb  = (cpu_rd_in || cpu_wr_in) && (w_cpu_vram || w_cpu_oam) && !r_pend_vld;
  assign w_cpu_tgt  = w_cpu_oam;
  assign w_cpu_blk  = w_cpu_tgt ? oam_blocked(lcd_en_in, mode_in)
                                : vram_blocked(lcd_en_in, mode_in);
  assign w_cpu_conf = w_ppu_ram[w_cpu_tgt];
  assign w_new_go   = w_cpu_stb && !w_cpu_blk && !w_cpu_conf;
  assign w_new_pend = w_cpu_stb && !w_cpu_blk &&  w_cpu_conf;
  assign w_blk_rd   = w_cpu_stb &&  w_cpu_blk && !cpu_wr_in;

  // A stalled access always issues the next clock: its PPU port is then in WAIT.
  assign w_go       = w_new_go || r_pend_vld;
  assign w_go_we    = r_pend_vld ? r_pend_we    : cpu_wr_in;
  assign w_go_tgt   = r_pend_vld ? r_pend_tgt   : w_cpu_tgt;
  assign w_go_addr  = r_pend_vld ? r_pend_addr  : cpu_addr_in[VA_W-1:0];
  assign w_go_wdata = r_pend_vld ? r_pend_wdata : cpu_wdata_in;

  assign w_vram_addr = w_ppu_ram[0] ? ppu_addr_in[VA_W-1:0] : w_go_addr;
  assign w_vram_we   = w_go && w_go_we && !w_go_tgt && !w_ppu_ram[0];
  assign w_oam_addr  = w_ppu_ram[1] ? oam_addr_in[7:0] : w_go_addr[7:0];
  assign w_oam_we    = w_go && w_go_we &&  w_go_tgt && !w_ppu_ram[1];

  video_bram #(.DEPTH(VRAM_DEPTH), .ADDR_W(VA_W), .READ_LATENCY(READ_LATENCY)) u_vram (
    .i_clk(clk_in), .i_we(w_vram_we), .i_addr(w_vram_addr),
    .i_wdata(w_go_wdata), .o_rdata(w_ram_q[0])
  );

  video_bram #(.DEPTH(OAM_DEPTH), .ADDR_W(8), .READ_LATENCY(READ_LATENCY)) u_oam (
    .i_clk(clk_in), .i_we(w_oam_we), .i_addr(w_oam_addr),
    .i_wdata(w_go_wdata), .o_rdata(w_ram_q[1])
  );

  // One-deep pending slot for a CPU access that lost to the PPU.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_pend_vld <= 1'b0;
    else        r_pend_vld <= w_new_pend;
  end

  // Pending payload, captured alongside the slot becoming valid.
  always_ff @(posedge clk_in) begin
    if (w_new_pend) begin
      r_pend_we    <= cpu_wr_in;
      r_pend_tgt   <= w_cpu_tgt;
      r_pend_addr  <= cpu_addr_in[VA_W-1:0];
      r_pend_wdata <= cpu_wdata_in;
    end
  end

  // Track issued CPU reads so the RAM output is captured when it emerges.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_rd_sr <= '0;
    else begin
      r_rd_sr[0] <= w_go && !w_go_we;
      for (int i = 1; i < READ_LATENCY; i++) r_rd_sr[i] <= r_rd_sr[i-1];
    end
  end

  // Which RAM each tracked read came from.
  always_ff @(posedge clk_in) begin
    r_tgt_sr[0] <= w_go_tgt;
    for (int i = 1; i < READ_LATENCY; i++) r_tgt_sr[i] <= r_tgt_sr[i-1];
  end

  // CPU read response: real data from the RAM, or FF one clock after a blocked read.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_rdata_out       <= 8'hFF;
      cpu_rdata_valid_out <= 1'b0;
    end else begin
      cpu_rdata_valid_out <= 1'b0;
      if (r_rd_sr[READ_LATENCY-1]) begin
        cpu_rdata_out       <= w_ram_q[r_tgt_sr[READ_LATENCY-1]];
        cpu_rdata_valid_out <= 1'b1;
      end else if (w_blk_rd) begin
        cpu_rdata_out       <= 8'hFF;
        cpu_rdata_valid_out <= 1'b1;
      end
    end
  end

  // PPU response FSM next state, one per port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_next[p] = r_state[p];
      case (r_state[p])
        PPU_IDLE: if (w_acc[p]) w_next[p] = PPU_WAIT;
        PPU_WAIT: if (r_cnt[p] == CNT_LAST) w_next[p] = PPU_HOLD;
        PPU_HOLD: if (tclk_in) w_next[p] = w_acc[p] ? PPU_WAIT : PPU_IDLE;
        default:  w_next[p] = PPU_IDLE;
      endcase
    end
  end

  // PPU response FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int p = 0; p < 2; p++) r_state[p] <= PPU_IDLE;
    end else begin
      for (int p = 0; p < 2; p++) r_state[p] <= w_next[p];
    end
  end

  // Latency counter, range flag and response data per PPU port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_oor <= '0;
      for (int p = 0; p < 2; p++) begin
        r_cnt[p]  <= '0;
        r_data[p] <= 8'hFF;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_acc[p]) begin
          r_cnt[p] <= '0;
          r_oor[p] <= !w_ppu_hit[p];
        end else if (r_state[p] == PPU_WAIT) begin
          r_cnt[p] <= r_cnt[p] + 2'd1;
        end
        if ((r_state[p] == PPU_WAIT) && (r_cnt[p] == CNT_LAST))
          r_data[p] <= r_oor[p] ? 8'hFF : w_ram_q[p];
      end
    end
  end

  assign ppu_data_out       = r_data[0];
  assign ppu_data_valid_out = (r_state[0] == PPU_HOLD);
  assign oam_data_out       = r_data[1];
  assign oam_data_valid_out = (r_state[1] == PPU_HOLD);

endmodule

// File: tb/tb_video_mem_responder.sv
// Directed bench for video_mem_responder: a table of CPU transactions
// followed by hand-written PPU/arbitration/reset sequences.
module tb_video_mem_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst, tclk, lcd, ppu_av, oam_av, cpu_rd, cpu_wr;
  logic [1:0]  mode;
  logic [15:0] ppu_addr, oam_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  ppu_data, oam_data, cpu_rdata;
  logic        ppu_dv, oam_dv, cpu_rv;

  int n_tests = 0;
  int n_fail  = 0;

  video_mem_responder #(.READ_LATENCY(RL), .VRAM_DEPTH(8192), .OAM_DEPTH(160)) dut (
    .clk_in(clk), .rst_in(rst), .tclk_in(tclk), .mode_in(mode), .lcd_en_in(lcd),
    .ppu_addr_in(ppu_addr), .ppu_addr_valid_in(ppu_av),
    .ppu_data_out(ppu_data), .ppu_data_valid_out(ppu_dv),
    .oam_addr_in(oam_addr), .oam_addr_valid_in(oam_av),
    .oam_data_out(oam_data), .oam_data_valid_out(oam_dv),
    .cpu_addr_in(cpu_addr), .cpu_rd_in(cpu_rd), .cpu_wr_in(cpu_wr),
    .cpu_wdata_in(cpu_wdata), .cpu_rdata_out(cpu_rdata), .cpu_rdata_valid_out(cpu_rv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  mode;
    logic [1:0]  mode_post;
    logic        lcd;
    logic        exp_rsp;
    logic [7:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [7:0] wd, input logic [1:0] m, input logic [1:0] mp,
                              input logic l, input logic er, input logic [7:0] ed, input int el);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.mode = m; v.mode_post = mp;
    v.lcd = l; v.exp_rsp = er; v.exp_data = ed; v.exp_lat = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ppu_req(input int p, input logic [15:0] a);
    tclk = 1'b1;
    if (p == 0) begin ppu_addr = a; ppu_av = 1'b1; end
    else        begin oam_addr = a; oam_av = 1'b1; end
    tick();
    tclk = 1'b0; ppu_av = 1'b0; oam_av = 1'b0;
  endtask

  // Called right after the accepting edge (cycle 1); returns on the first valid cycle.
  task automatic ppu_wait(input int p, output int lat, output logic [7:0] d);
    bit found = 0;
    lat = 0; d = 8'h00;
    for (int c = 1; c <= 10 && !found; c++) begin
      if ((p == 0) ? ppu_dv : oam_dv) begin
        found = 1; lat = c; d = (p == 0) ? ppu_data : oam_data;
      end else begin
        tick();
      end
    end
  endtask

  task automatic ppu_release();
    tclk = 1'b1;
    tick();
    tclk = 1'b0;
  endtask

  task automatic cpu_run(input vec_t v, input string name);
    int npulse = 0;
    int lat = 0;
    logic [7:0] d = 8'h00;
    mode = v.mode; lcd = v.lcd; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_rd = v.rd; cpu_wr = v.wr;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0; mode = v.mode_post;
    for (int c = 1; c <= 8; c++) begin
      if (cpu_rv) begin
        npulse++;
        if (lat == 0) begin lat = c; d = cpu_rdata; end
      end
      tick();
    end
    check({name, "_pulses"}, npulse, v.exp_rsp ? 1 : 0);
    if (v.exp_rsp && npulse > 0) begin
      check({name, "_data"}, d, v.exp_data);
      check({name, "_lat"}, lat, v.exp_lat);
    end
    mode = 2'd0;
  endtask

  initial begin
    int lat, plat, clat;
    int nv;
    logic [7:0] d, pd, cd;

    rst = 1'b1; tclk = 1'b0; mode = 2'd0; lcd = 1'b0;
    ppu_addr = '0; ppu_av = 1'b0; oam_addr = '0; oam_av = 1'b0;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
    repeat (3) tick();
    check("rst_ppu_valid", ppu_dv, 0);
    check("rst_oam_valid", oam_dv, 0);
    check("rst_cpu_valid", cpu_rv, 0);
    check("rst_ppu_data", ppu_data, 8'hFF);
    check("rst_oam_data", oam_data, 8'hFF);
    check("rst_cpu_data", cpu_rdata, 8'hFF);
    rst = 1'b0;
    tick();

    //             rd wr  addr      wd     m     mpost lcd rsp data   lat
    tbl.push_back(mk(0, 1, 16'h8010, 8'hA5, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'h8010, 8'h00, 2'd0, 2'd0, 1, 1, 8'hA5, RL+1));
    tbl.push_back(mk(0, 1, 16'h8000, 8'h11, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 16'h8000, 8'h3C, 2'd3, 2'd3, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'h8000, 8'h00, 2'd3, 2'd3, 1, 1, 8'hFF, 1));
    tbl.push_back(mk(1, 0, 16'h8000, 8'h00, 2'd0, 2'd0, 1, 1, 8'h11, RL+1));
    tbl.push_back(mk(0, 1, 16'hFE00, 8'h5A, 2'd1, 2'd1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'hFE00, 8'h00, 2'd2, 2'd2, 1, 1, 8'hFF, 1));
    tbl.push_back(mk(1, 0, 16'hFE00, 8'h00, 2'd2, 2'd2, 0, 1, 8'h5A, RL+1));
    tbl.push_back(mk(1, 0, 16'hFE00, 8'h00, 2'd3, 2'd3, 1, 1, 8'hFF, 1));
    tbl.push_back(mk(0, 1, 16'h9FFF, 8'h77, 2'd2, 2'd2, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'h9FFF, 8'h00, 2'd1, 2'd1, 1, 1, 8'h77, RL+1));
    tbl.push_back(mk(0, 1, 16'hFE9F, 8'h99, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'hFE9F, 8'h00, 2'd0, 2'd0, 1, 1, 8'h99, RL+1));
    tbl.push_back(mk(1, 0, 16'hFEA4, 8'h00, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 16'hFEA4, 8'h42, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'hC000, 8'h00, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'hA000, 8'h00, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 16'h8020, 8'hE1, 2'd0, 2'd0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 16'h8020, 8'h00, 2'd0, 2'd0, 1, 1, 8'hE1, RL+1));
    tbl.push_back(mk(1, 0, 16'h8010, 8'h00, 2'd0, 2'd3, 1, 1, 8'hA5, RL+1));

    foreach (tbl[i]) cpu_run(tbl[i], $sformatf("vec%0d", i));

    lcd = 1'b0; mode = 2'd0;

    // PPU VRAM fetch: data held until the next strobe inclusive, cleared after.
    ppu_req(0, 16'h8010);
    check("vram_fetch_wait", ppu_dv, 0);
    ppu_wait(0, lat, d);
    check("vram_fetch_lat", lat, RL+1);
    check("vram_fetch_data", d, 8'hA5);
    repeat (3) tick();
    check("vram_hold_valid", ppu_dv, 1);
    check("vram_hold_data", ppu_data, 8'hA5);
    tclk = 1'b1;
    #1;
    check("vram_strobe_valid", ppu_dv, 1);
    tick();
    tclk = 1'b0;
    check("vram_cleared", ppu_dv, 0);

    // CPU read colliding with a PPU VRAM acceptance stalls one clock.
    tclk = 1'b1; ppu_addr = 16'h8010; ppu_av = 1'b1; cpu_addr = 16'h9FFF; cpu_rd = 1'b1;
    tick();
    tclk = 1'b0; ppu_av = 1'b0; cpu_rd = 1'b0;
    plat = 0; clat = 0; pd = 8'h00; cd = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      if (ppu_dv && plat == 0) begin plat = c; pd = ppu_data; end
      if (cpu_rv && clat == 0) begin clat = c; cd = cpu_rdata; end
      tick();
    end
    check("stall_ppu_lat", plat, RL+1);
    check("stall_ppu_data", pd, 8'hA5);
    check("stall_cpu_lat", clat, RL+2);
    check("stall_cpu_data", cd, 8'h77);
    ppu_release();

    // OAM: request during WAIT ignored, back-to-back request from HOLD.
    ppu_req(1, 16'hFE00);
    tclk = 1'b1; oam_addr = 16'hFE9F; oam_av = 1'b1;
    tick();
    tclk = 1'b0; oam_av = 1'b0;
    check("oam_wait_ignore", oam_dv, 0);
    tick();
    check("oam_first_valid", oam_dv, 1);
    check("oam_first_data", oam_data, 8'h5A);
    ppu_req(1, 16'hFE9F);
    check("oam_b2b_gap", oam_dv, 0);
    ppu_wait(1, lat, d);
    check("oam_b2b_lat", lat, RL+1);
    check("oam_b2b_data", d, 8'h99);
    ppu_release();

    // Same-clock PPU OAM fetch and CPU write of the same byte.
    tclk = 1'b1; oam_addr = 16'hFE00; oam_av = 1'b1;
    cpu_addr = 16'hFE00; cpu_wr = 1'b1; cpu_wdata = 8'h77;
    tick();
    tclk = 1'b0; oam_av = 1'b0; cpu_wr = 1'b0;
    ppu_wait(1, lat, d);
    check("rw_clash_old_data", d, 8'h5A);
    ppu_release();
    ppu_req(1, 16'hFE00);
    ppu_wait(1, lat, d);
    check("rw_clash_refetch", d, 8'h77);
    ppu_release();

    // OAM fetch in the unused $FEA0-$FEFF window answers FF.
    ppu_req(1, 16'hFEA4);
    ppu_wait(1, lat, d);
    check("oam_oor_lat", lat, RL+1);
    check("oam_oor_data", d, 8'hFF);
    ppu_release();

    // Reset while a fetch is in WAIT drops it.
    ppu_req(0, 16'h8010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (ppu_dv) nv++;
      tick();
    end
    check("rst_wait_no_valid", nv, 0);
    check("rst_wait_data", ppu_data, 8'hFF);
    check("rst_wait_cpu_data", cpu_rdata, 8'hFF);
    ppu_req(0, 16'h8010);
    ppu_wait(0, lat, d);
    check("post_rst_lat", lat, RL+1);
    check("post_rst_data", d, 8'hA5);
    ppu_release();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
